conv_window_scheduler: RTL and testbench

Sequences one image through the convolution window buffer and shares a pool of `Lanes` dot-product lanes among `NumberOfK` kernels. It sits between the pixel source and the convolution buffer on one side, and the dot-product array on the other. Per image it resets the buffer, steps it one pixel at a time, and captures each emitted N×N window. It then issues that window over ceil(NumberOfK/Lanes) passes before stepping the buffer again.

---
 rtl/conv_window_scheduler.sv | 160 ++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Steps the convolution buffer one pixel at a time and shares the dot-product lanes among the kernels.
// Optional build macro CONV_SCHED_PERF_EN adds a saturating backpressure stall counter on port stall_cycles.
module conv_window_scheduler #(
    parameter int unsigned N          = 3,
    parameter int unsigned BitSize    = 32,
    parameter int unsigned ImageWidth = 4,
    parameter int unsigned NumberOfK  = 4,
    parameter int unsigned Lanes      = 2
) (
    input  logic                              clk,
    input  logic                              res,
    input  logic                              start,
    output logic                              busy,
    input  logic                              pix_valid,
    input  logic [BitSize-1:0]                pix_data,
    output logic                              pix_ready,
    output logic                              buf_res_n,
    output logic                              buf_in_valid,
    output logic [BitSize-1:0]                buf_in_data,
    input  logic                              buf_out_valid,
    input  logic [N*N*BitSize-1:0]            buf_out_data,
    output logic                              dp_valid,
    input  logic                              dp_ready,
    output logic [N*N*BitSize-1:0]            dp_window,
    output logic [$clog2(NumberOfK):0]        dp_kbase,
    output logic [Lanes-1:0]                  dp_lane_en,
    output logic                              img_done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int unsigned WinW   = N * N * BitSize;
    localparam int unsigned KW     = $clog2(NumberOfK) + 1;
    localparam int unsigned Passes = (NumberOfK + Lanes - 1) / Lanes;
    localparam int unsigned Total  = ImageWidth * ImageWidth;
    localparam int unsigned PixW   = $clog2(Total + 1);
    localparam int unsigned WinCW  = (Total > 1) ? $clog2(Total) : 1;
    localparam int unsigned PassW  = (Passes > 1) ? $clog2(Passes) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BRST  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PixW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [WinCW-1:0] win_cnt_q, win_cnt_d;
    logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
    logic [WinW-1:0]  window_q, window_d;
    logic             feeding;
    logic             pix_left;

    // Pixel path: pass-through while pixels remain, zero-filled drain steps afterwards.
    assign feeding      = (state_q == S_FEED);
    assign pix_left     = (pix_cnt_q < PixW'(Total));
    assign pix_ready    = feeding & pix_left;
    assign buf_in_valid = feeding & (pix_left ? pix_valid : 1'b1);
    assign buf_in_data  = (feeding & pix_left) ? pix_data : '0;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        win_cnt_d  = win_cnt_q;
        pass_cnt_d = pass_cnt_q;
        window_d   = window_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_BRST;
                    pix_cnt_d  = '0;
                    win_cnt_d  = '0;
                    pass_cnt_d = '0;
                end
            end
            S_BRST: state_d = S_FEED;
            S_FEED: begin
                if (pix_ready & pix_valid) begin
                    pix_cnt_d = pix_cnt_q + PixW'(1);
                end
                if (buf_in_valid & buf_out_valid) begin
                    window_d   = buf_out_data;
                    pass_cnt_d = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dp_ready) begin
                    if (pass_cnt_q < PassW'(Passes - 1)) begin
                        pass_cnt_d = pass_cnt_q + PassW'(1);
                    end else if (win_cnt_q == WinCW'(Total - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        win_cnt_d = win_cnt_q + WinCW'(1);
                        state_d   = S_FEED;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            win_cnt_q  <= '0;
            pass_cnt_q <= '0;
            window_q   <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            win_cnt_q  <= win_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            window_q   <= window_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign buf_res_n = (state_q != S_IDLE) && (state_q != S_BRST);
    assign dp_valid  = (state_q == S_ISSUE);
    assign img_done  = (state_q == S_DONE);
    assign dp_window = window_q;
    assign dp_kbase  = KW'(pass_cnt_q) * KW'(Lanes);

    // Lanes past the last kernel are masked on the partial final pass.
    always_comb begin
        dp_lane_en = '0;
        for (int unsigned l = 0; l < Lanes; l++) begin
            dp_lane_en[l] = (state_q == S_ISSUE) && ((32'(dp_kbase) + l) < NumberOfK);
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == S_ISSUE) && !dp_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: two instances (NumberOfK 4 and 3) share a behavioural window buffer.
// Honours CONV_SCHED_PERF_EN by also checking stall_cycles.
module tb_conv_window_scheduler;

    localparam int unsigned B   = 32;
    localparam int unsigned WW  = 9 * B;
    localparam int          D   = 5;
    localparam int          TOT = 16;

    typedef struct {
        bit toggle;
        int stall_len;
        int exp_pix;
        int exp_cap;
        int exp_hs;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, start, pix_valid, dp_ready;
    logic [B-1:0]  pix_data;

    logic          busy_a, pix_ready_a, buf_res_n_a, buf_in_valid_a, dp_valid_a, img_done_a;
    logic [B-1:0]  buf_in_data_a;
    logic [WW-1:0] dp_window_a;
    logic [2:0]    dp_kbase_a;
    logic [1:0]    lane_en_a;
    logic          busy_b, pix_ready_b, buf_res_n_b, buf_in_valid_b, dp_valid_b, img_done_b;
    logic [B-1:0]  buf_in_data_b;
    logic [WW-1:0] dp_window_b;
    logic [2:0]    dp_kbase_b;
    logic [1:0]    lane_en_b;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]   stall_a, stall_b;
`endif

    // Behavioural buffer: window = last nine inputs, valid from step D onwards.
    logic [8*B-1:0] sr = '0;
    int             stepc = 0;
    logic           buf_out_valid;
    logic [WW-1:0]  buf_out_data;
    assign buf_out_valid = buf_in_valid_a && (stepc >= D);
    assign buf_out_data  = {sr, buf_in_data_a};
    always @(posedge clk) begin
        if (!buf_res_n_a) begin
            sr    <= '0;
            stepc <= 0;
        end else if (buf_in_valid_a) begin
            sr    <= {sr[7*B-1:0], buf_in_data_a};
            stepc <= stepc + 1;
        end
    end

    conv_window_scheduler u_a (
        .clk(clk), .res(res), .start(start), .busy(busy_a),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready_a),
        .buf_res_n(buf_res_n_a), .buf_in_valid(buf_in_valid_a), .buf_in_data(buf_in_data_a),
        .buf_out_valid(buf_out_valid), .buf_out_data(buf_out_data),
        .dp_valid(dp_valid_a), .dp_ready(dp_ready), .dp_window(dp_window_a),
        .dp_kbase(dp_kbase_a), .dp_lane_en(lane_en_a), .img_done(img_done_a)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cycles(stall_a)
`endif
    );

    conv_window_scheduler #(.NumberOfK(3)) u_b (
        .clk(clk), .res(res), .start(start), .busy(busy_b),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready_b),
        .buf_res_n(buf_res_n_b), .buf_in_valid(buf_in_valid_b), .buf_in_data(buf_in_data_b),
        .buf_out_valid(buf_out_valid), .buf_out_data(buf_out_data),
        .dp_valid(dp_valid_b), .dp_ready(dp_ready), .dp_window(dp_window_b),
        .dp_kbase(dp_kbase_b), .dp_lane_en(lane_en_b), .img_done(img_done_b)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cycles(stall_b)
`endif
    );

    int tests = 0, fails = 0;
    int acc, cap, hs, hs_b, done_cnt, brst_cnt, steps, stalled;
    int kb_err, win_err, data_err, pr_err, stall_err, busy_err;
    logic [WW-1:0] held_win;
    logic [2:0]    held_kb;
    bit held_ok, done_prev, mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Window w is captured on buffer step D+w; step s carries pixel s+1, zero outside the image.
    function automatic logic [WW-1:0] exp_win(input int w);
        logic [WW-1:0] r;
        r = '0;
        for (int j = 0; j < 9; j++) begin
            int s;
            s = D + w - j;
            r[j*B +: B] = (s >= 0 && s < TOT) ? 32'(s + 1) : 32'd0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid && pix_ready_a) acc++;
            if (pix_ready_a && !(busy_a && buf_res_n_a && !dp_valid_a && !img_done_a)) pr_err++;
            if (busy_a && !buf_res_n_a) brst_cnt++;
            if (buf_in_valid_a) begin
                if (buf_in_data_a !== ((steps < TOT) ? 32'(steps + 1) : 32'd0)) data_err++;
                steps++;
            end
            if (buf_in_valid_a && buf_out_valid) cap++;
            if (dp_valid_a && dp_ready) begin
                if (dp_kbase_a !== 3'((hs % 2) * 2) || lane_en_a !== 2'b11) kb_err++;
                if (dp_window_a !== exp_win(hs / 2)) win_err++;
                hs++;
            end
            if (dp_valid_b && dp_ready) begin
                if (dp_kbase_b !== 3'((hs_b % 2) * 2) ||
                    lane_en_b !== ((hs_b % 2 == 0) ? 2'b11 : 2'b01)) kb_err++;
                if (dp_window_b !== exp_win(hs_b / 2)) win_err++;
                hs_b++;
            end
            if (dp_valid_a && !dp_ready) begin
                if (!held_ok) begin
                    held_win = dp_window_a;
                    held_kb  = dp_kbase_a;
                    held_ok  = 1'b1;
                end else if (dp_window_a !== held_win || dp_kbase_a !== held_kb) begin
                    stall_err++;
                end
                if (buf_in_valid_a) stall_err++;
            end
            if (done_prev && busy_a) busy_err++;
            if (img_done_a) done_cnt++;
            done_prev = img_done_a;
        end
    end

    task automatic run_image(input vec_t v, input string nm, input bit abort);
        int cyc;
        bit fin;
        acc = 0; cap = 0; hs = 0; hs_b = 0; done_cnt = 0; brst_cnt = 0; steps = 0; stalled = 0;
        kb_err = 0; win_err = 0; data_err = 0; pr_err = 0; stall_err = 0; busy_err = 0;
        held_ok = 1'b0; done_prev = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; dp_ready = 1'b1; pix_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy_t1"}, 32'(busy_a), 32'd1);
        chk({nm, "_bufres_t1"}, 32'(buf_res_n_a), 32'd0);
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start     = (cyc == 3 || cyc == 40);
            pix_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
            pix_data  = (acc < TOT) ? 32'(acc + 1) : 32'hDEAD_BEEF;
            if (dp_valid_a && hs == 0 && stalled < v.stall_len) begin
                dp_ready = 1'b0;
                stalled++;
            end else begin
                dp_ready = 1'b1;
            end
            if (abort && dp_valid_a && hs == 14) fin = 1'b1;
            if (!abort && done_cnt >= 1 && !img_done_a) fin = 1'b1;
        end
        start = 1'b0;
        chk({nm, "_timeout"}, 32'(fin), 32'd1);
        if (!abort) begin
            @(negedge clk); #1;
            mon_en = 1'b0;
            chk({nm, "_pix"}, acc, v.exp_pix);
            chk({nm, "_cap"}, cap, v.exp_cap);
            chk({nm, "_hs_a"}, hs, v.exp_hs);
            chk({nm, "_hs_b"}, hs_b, v.exp_hs);
            chk({nm, "_done"}, done_cnt, v.exp_done);
            chk({nm, "_brst"}, brst_cnt, 32'd1);
            chk({nm, "_steps"}, steps, TOT + D);
            chk({nm, "_kbase"}, kb_err, 32'd0);
            chk({nm, "_window"}, win_err, 32'd0);
            chk({nm, "_bufdata"}, data_err, 32'd0);
            chk({nm, "_pixready"}, pr_err, 32'd0);
            chk({nm, "_stall"}, stall_err, 32'd0);
            chk({nm, "_busyfall"}, busy_err, 32'd0);
            chk({nm, "_idle"}, 32'(busy_a), 32'd0);
`ifdef CONV_SCHED_PERF_EN
            chk({nm, "_stallcnt"}, stall_a, v.stall_len);
`endif
        end
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{toggle: 1'b0, stall_len: 0, exp_pix: 16, exp_cap: 16, exp_hs: 32, exp_done: 1};
        vecs[1] = '{toggle: 1'b0, stall_len: 5, exp_pix: 16, exp_cap: 16, exp_hs: 32, exp_done: 1};
        vecs[2] = '{toggle: 1'b1, stall_len: 0, exp_pix: 16, exp_cap: 16, exp_hs: 32, exp_done: 1};
        vecs[3] = '{toggle: 1'b1, stall_len: 3, exp_pix: 16, exp_cap: 16, exp_hs: 32, exp_done: 1};

        res = 1'b1; start = 1'b0; pix_valid = 1'b1; pix_data = 32'h1234_5678; dp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready_a), 32'd0);
        chk("rst_buf_in_valid", 32'(buf_in_valid_a), 32'd0);
        chk("rst_buf_in_data", buf_in_data_a, 32'd0);
        chk("rst_buf_res_n", 32'(buf_res_n_a), 32'd0);
        chk("rst_dp_valid", 32'(dp_valid_a), 32'd0);
        chk("rst_img_done", 32'(img_done_a), 32'd0);
        chk("rst_dp_window", 32'(dp_window_a == '0), 32'd1);
        chk("rst_dp_kbase", 32'(dp_kbase_a), 32'd0);
        chk("rst_lane_en", 32'(lane_en_a), 32'd0);
        @(posedge clk); #1;
        res = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_image(vecs[i], $sformatf("v%0d", i), 1'b0);
        end

        // Reset while window 7 is being issued, then a clean image.
        run_image(vecs[0], "abort", 1'b1);
        chk("abort_cap", cap, 32'd8);
        res = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_buf_res_n", 32'(buf_res_n_a), 32'd0);
        chk("abort_dp_valid", 32'(dp_valid_a), 32'd0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_hold_buf_res_n", 32'(buf_res_n_a), 32'd0);
        res = 1'b0;
        run_image(vecs[0], "post_abort", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
